// File: rtl/tile_psum_collector.sv
// Partial-sum collector: reduces tile rows per column, accumulates num_pass beats per group.
// Build macro TILE_PSUM_SAT_EN selects saturating accumulation (default: modulo-2^AC_BW wrap).
module tile_psum_collector #(
  parameter int AK_BW   = 20,
  parameter int AC_BW   = 24,
  parameter int COLS    = 5,
  parameter int T_ROWS  = 5,
  parameter int T_COLS  = 5,
  parameter int PASS_BW = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [PASS_BW-1:0]                 i_num_pass,
  input  logic                               i_clr,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [AK_BW*COLS*T_ROWS*T_COLS-1:0] i_psum,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [AC_BW*COLS*T_COLS-1:0]       o_acc,
  output logic                               o_busy,
  output logic                               o_sat,
  output logic [1:0]                         o_dbg_state
);

  localparam int LANES = T_COLS * COLS;
  localparam int S1_BW = AK_BW + $clog2(T_ROWS);
  localparam logic signed [AC_BW-1:0] ACC_MAX = {1'b0, {(AC_BW-1){1'b1}}};
  localparam logic signed [AC_BW-1:0] ACC_MIN = {1'b1, {(AC_BW-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_FLUSH, ST_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [PASS_BW-1:0]       cnt_q, cnt_d;
  logic [PASS_BW-1:0]       num_pass_q, num_pass_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q, s1_last_d;
  logic [LANES*S1_BW-1:0]   s1_sum_q, s1_sum_d;
  logic [LANES*AC_BW-1:0]   acc_q, acc_d;
  logic [LANES*AC_BW-1:0]   o_acc_q, o_acc_d;
  logic                     o_valid_q, o_valid_d;
  logic                     sat_q, sat_d;
  logic                     accept, start_ok, out_fire, last_beat;

  // Handshakes: a beat moves when i_valid && o_ready; a result moves when o_valid && i_ready.
  // A producer holds its data stable while valid is high and the other side is not ready.

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_ACCUM;
      ST_ACCUM: if (accept && last_beat) state_d = ST_FLUSH;
      ST_FLUSH: if (s1_valid_q && s1_last_q) state_d = ST_DRAIN;
      ST_DRAIN: if (out_fire) state_d = ST_ACCUM;
      default:  state_d = ST_IDLE;
    endcase
    if (i_clr) state_d = ST_IDLE;
  end

  always_comb begin
    o_ready     = (state_q == ST_ACCUM) && (cnt_q < num_pass_q);
    o_busy      = (state_q != ST_IDLE);
    o_dbg_state = state_q;
    accept      = i_valid && o_ready;
    start_ok    = (state_q == ST_IDLE) && i_start && !i_clr;
    out_fire    = o_valid_q && i_ready;
  end

  always_comb begin
    cnt_d      = cnt_q;
    num_pass_d = num_pass_q;
    last_beat  = (cnt_q == num_pass_q - PASS_BW'(1));
    if (start_ok) begin
      cnt_d      = '0;
      num_pass_d = (i_num_pass == '0) ? PASS_BW'(1) : i_num_pass;
    end
    if (accept)   cnt_d = cnt_q + PASS_BW'(1);
    if (out_fire) cnt_d = '0;
    if (i_clr)    cnt_d = '0;
    s1_valid_d = accept && !i_clr;
    s1_last_d  = accept && last_beat;
  end

  // Stage 1: row reduction, widened by clog2(T_ROWS) so it can never overflow.
  logic signed [AK_BW-1:0] lane_v;
  logic signed [S1_BW-1:0] col_sum;
  always_comb begin
    s1_sum_d = s1_sum_q;
    lane_v   = '0;
    col_sum  = '0;
    if (accept) begin
      for (int c = 0; c < T_COLS; c++) begin
        for (int k = 0; k < COLS; k++) begin
          col_sum = '0;
          for (int r = 0; r < T_ROWS; r++) begin
            lane_v  = i_psum[((c*T_ROWS + r)*COLS + k)*AK_BW +: AK_BW];
            col_sum = col_sum + S1_BW'(lane_v);
          end
          s1_sum_d[(c*COLS + k)*S1_BW +: S1_BW] = col_sum;
        end
      end
    end
  end

  // Stage 2: one guard bit above AC_BW detects overflow before clamp or wrap.
  logic signed [S1_BW-1:0] s1_lane;
  logic signed [AC_BW-1:0] acc_lane;
  logic signed [AC_BW:0]   sum_w;
  logic signed [AC_BW-1:0] res_w;
  always_comb begin
    acc_d     = acc_q;
    o_acc_d   = o_acc_q;
    o_valid_d = o_valid_q;
    sat_d     = sat_q;
    s1_lane   = '0;
    acc_lane  = '0;
    sum_w     = '0;
    res_w     = '0;
    if (out_fire) o_valid_d = 1'b0;
    if (s1_valid_q) begin
      for (int j = 0; j < LANES; j++) begin
        s1_lane  = s1_sum_q[j*S1_BW +: S1_BW];
        acc_lane = acc_q[j*AC_BW +: AC_BW];
        sum_w    = (AC_BW+1)'(acc_lane) + (AC_BW+1)'(s1_lane);
`ifdef TILE_PSUM_SAT_EN
        if (sum_w[AC_BW] != sum_w[AC_BW-1]) begin
          res_w = sum_w[AC_BW] ? ACC_MIN : ACC_MAX;
          sat_d = 1'b1;
        end else begin
          res_w = sum_w[AC_BW-1:0];
        end
`else
        res_w = sum_w[AC_BW-1:0];
`endif
        if (s1_last_q) begin
          o_acc_d[j*AC_BW +: AC_BW] = res_w;
          acc_d[j*AC_BW +: AC_BW]   = '0;
        end else begin
          acc_d[j*AC_BW +: AC_BW]   = res_w;
        end
      end
      if (s1_last_q) o_valid_d = 1'b1;
    end
    if (start_ok) sat_d = 1'b0;
    if (i_clr) begin
      acc_d     = '0;
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      num_pass_q <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '0;
      acc_q      <= '0;
      o_acc_q    <= '0;
      o_valid_q  <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      num_pass_q <= num_pass_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_sum_q   <= s1_sum_d;
      acc_q      <= acc_d;
      o_acc_q    <= o_acc_d;
      o_valid_q  <= o_valid_d;
      sat_q      <= sat_d;
    end
  end

  assign o_acc   = o_acc_q;
  assign o_valid = o_valid_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_tile_psum_collector.sv
// Directed bench for tile_psum_collector with hand-computed lane results.
module tb_tile_psum_collector;

  localparam int AK_BW   = 20;
  localparam int AC_BW   = 24;
  localparam int COLS    = 5;
  localparam int T_ROWS  = 5;
  localparam int T_COLS  = 5;
  localparam int PASS_BW = 4;
  localparam int PSUM_W  = AK_BW * COLS * T_ROWS * T_COLS;
  localparam int LANES   = COLS * T_COLS;
  localparam int ACC_W   = AC_BW * LANES;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               i_start;
  logic [PASS_BW-1:0] i_num_pass;
  logic               i_clr;
  logic               i_valid;
  logic               o_ready;
  logic [PSUM_W-1:0]  i_psum;
  logic               o_valid;
  logic               i_ready;
  logic [ACC_W-1:0]   o_acc;
  logic               o_busy;
  logic               o_sat;
  logic [1:0]         o_dbg_state;

  int checks = 0;
  int errors = 0;

  tile_psum_collector #(
    .AK_BW(AK_BW), .AC_BW(AC_BW), .COLS(COLS),
    .T_ROWS(T_ROWS), .T_COLS(T_COLS), .PASS_BW(PASS_BW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_pass(i_num_pass),
    .i_clr(i_clr), .i_valid(i_valid), .o_ready(o_ready), .i_psum(i_psum),
    .o_valid(o_valid), .i_ready(i_ready), .o_acc(o_acc), .o_busy(o_busy),
    .o_sat(o_sat), .o_dbg_state(o_dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [PASS_BW-1:0] np);
    i_start    = 1'b1;
    i_num_pass = np;
    tick();
    i_start    = 1'b0;
  endtask

  task automatic handshake();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
  endtask

  function automatic logic [PSUM_W-1:0] psum_all(input int v);
    logic [PSUM_W-1:0] p;
    p = '0;
    for (int s = 0; s < PSUM_W / AK_BW; s++) p[s*AK_BW +: AK_BW] = AK_BW'(v);
    return p;
  endfunction

  // Tile (r,c) lanes carry r+1.
  function automatic logic [PSUM_W-1:0] psum_rows();
    logic [PSUM_W-1:0] p;
    p = '0;
    for (int c = 0; c < T_COLS; c++)
      for (int r = 0; r < T_ROWS; r++)
        for (int k = 0; k < COLS; k++)
          p[((c*T_ROWS + r)*COLS + k)*AK_BW +: AK_BW] = AK_BW'(r + 1);
    return p;
  endfunction

  function automatic int bad_lanes(input int exp_v);
    int n;
    n = 0;
    for (int j = 0; j < LANES; j++)
      if ($signed(o_acc[j*AC_BW +: AC_BW]) !== exp_v) n++;
    return n;
  endfunction

  function automatic int lane0();
    return int'($signed(o_acc[AC_BW-1:0]));
  endfunction

  task automatic test_reset();
    int nb;
    rst = 1'b1;
    i_start = 1'($urandom_range(0, 1));
    i_num_pass = PASS_BW'($urandom_range(0, 15));
    i_clr = 1'($urandom_range(0, 1));
    i_valid = 1'($urandom_range(0, 1));
    i_ready = 1'($urandom_range(0, 1));
    for (int s = 0; s < PSUM_W / AK_BW; s++) i_psum[s*AK_BW +: AK_BW] = AK_BW'($urandom);
    tick();
    tick();
    checks++;
    if ({o_valid, o_ready, o_busy, o_sat} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got v/r/b/s=%b expected 0000", {o_valid, o_ready, o_busy, o_sat});
    end
    checks++;
    nb = bad_lanes(0);
    if (nb !== 0) begin
      errors++;
      $display("FAIL reset_acc: %0d lanes nonzero, lane0=%0d expected 0", nb, lane0());
    end
    checks++;
    if (o_dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", o_dbg_state);
    end
    rst = 1'b0; i_start = 0; i_clr = 0; i_valid = 0; i_ready = 0; i_num_pass = '0;
    i_psum = '0;
    tick();
  endtask

  task automatic test_single_pass(input logic [PASS_BW-1:0] np);
    int nb;
    start_run(np);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_np%0d: got %b expected 1", np, o_ready);
    end
    i_valid = 1'b1;
    i_psum  = psum_all(1);
    tick();
    i_valid = 1'b0;
    checks++;
    if ({o_valid, o_ready} !== 2'b00) begin
      errors++;
      $display("FAIL single_t1_np%0d: got valid/ready=%b expected 00", np, {o_valid, o_ready});
    end
    tick();
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid_np%0d: got %b expected 1", np, o_valid);
    end
    checks++;
    nb = bad_lanes(5);
    if (nb !== 0) begin
      errors++;
      $display("FAIL single_acc_np%0d: %0d bad lanes, lane0=%0d expected 5", np, nb, lane0());
    end
    handshake();
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_after_hs_np%0d: got valid/ready=%b expected 01", np, {o_valid, o_ready});
    end
    clr_pulse();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_clr_idle_np%0d: busy got %b expected 0", np, o_busy);
    end
  endtask

  task automatic test_multi_pass();
    int nb;
    start_run(4'd3);
    i_psum  = psum_rows();
    i_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (o_ready !== 1'b1) begin
        errors++;
        $display("FAIL multi_ready_beat%0d: got %b expected 1", b, o_ready);
      end
      tick();
    end
    i_valid = 1'b0;
    checks++;
    if ({o_ready, o_dbg_state} !== {1'b0, 2'd2}) begin
      errors++;
      $display("FAIL multi_flush: got ready=%b state=%0d expected ready=0 state=2", o_ready, o_dbg_state);
    end
    tick();
    checks++;
    if ({o_valid, o_ready, o_dbg_state} !== {1'b1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL multi_drain: got valid=%b ready=%b state=%0d expected 1 0 3", o_valid, o_ready, o_dbg_state);
    end
    checks++;
    nb = bad_lanes(45);
    if (nb !== 0) begin
      errors++;
      $display("FAIL multi_acc: %0d bad lanes, lane0=%0d expected 45", nb, lane0());
    end
    handshake();
    clr_pulse();
  endtask

  task automatic test_saturation(input int lane_val, input int exp_v, input logic exp_sat);
    int nb;
    start_run(4'd4);
    i_psum  = psum_all(lane_val);
    i_valid = 1'b1;
    repeat (4) tick();
    i_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_valid_%0d: got %b expected 1", lane_val, o_valid);
    end
    checks++;
    nb = bad_lanes(exp_v);
    if (nb !== 0) begin
      errors++;
      $display("FAIL sat_acc_%0d: %0d bad lanes, lane0=%0d expected %0d", lane_val, nb, lane0(), exp_v);
    end
    checks++;
    if (o_sat !== exp_sat) begin
      errors++;
      $display("FAIL sat_flag_%0d: got %b expected %b", lane_val, o_sat, exp_sat);
    end
    handshake();
    clr_pulse();
  endtask

  task automatic test_backpressure();
    int nb;
    start_run(4'd2);
    checks++;
    if (o_sat !== 1'b0) begin
      errors++;
      $display("FAIL bp_sat_cleared: got %b expected 0", o_sat);
    end
    i_psum  = psum_all(3);
    i_valid = 1'b1;
    repeat (2) tick();
    i_psum  = psum_all(7);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({o_valid, o_ready} !== 2'b10) begin
        errors++;
        $display("FAIL bp_stall_flags_c%0d: got valid/ready=%b expected 10", i, {o_valid, o_ready});
      end
      checks++;
      nb = bad_lanes(30);
      if (nb !== 0) begin
        errors++;
        $display("FAIL bp_stall_acc_c%0d: %0d bad lanes, lane0=%0d expected 30", i, nb, lane0());
      end
      tick();
    end
    i_psum = psum_all(1);
    handshake();
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_after_hs: got valid/ready=%b expected 01", {o_valid, o_ready});
    end
    repeat (2) tick();
    i_valid = 1'b0;
    tick();
    tick();
    checks++;
    nb = bad_lanes(10);
    if (o_valid !== 1'b1 || nb !== 0) begin
      errors++;
      $display("FAIL bp_next_group: valid=%b bad lanes=%0d lane0=%0d expected valid 1 lanes 10", o_valid, nb, lane0());
    end
    handshake();
    clr_pulse();
  endtask

  task automatic test_clear();
    int nb;
    logic saw_valid;
    start_run(4'd3);
    i_psum  = psum_all(4);
    i_valid = 1'b1;
    tick();
    i_start    = 1'b1;
    i_num_pass = 4'd1;
    tick();
    i_start = 1'b0;
    i_valid = 1'b0;
    clr_pulse();
    checks++;
    if ({o_busy, o_ready, o_dbg_state} !== 4'b0000) begin
      errors++;
      $display("FAIL clr_idle: got busy=%b ready=%b state=%0d expected 0 0 0", o_busy, o_ready, o_dbg_state);
    end
    saw_valid = 1'b0;
    repeat (4) begin
      if (o_valid !== 1'b0) saw_valid = 1'b1;
      tick();
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_result: got o_valid seen=%b expected 0", saw_valid);
    end
    i_start = 1'b1;
    i_clr   = 1'b1;
    tick();
    i_start = 1'b0;
    i_clr   = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_wins_start: busy got %b expected 0", o_busy);
    end
    start_run(4'd1);
    i_psum  = psum_all(2);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    checks++;
    nb = bad_lanes(10);
    if (o_valid !== 1'b1 || nb !== 0) begin
      errors++;
      $display("FAIL clr_restart: valid=%b bad lanes=%0d lane0=%0d expected valid 1 lanes 10", o_valid, nb, lane0());
    end
    handshake();
    clr_pulse();
  endtask

  initial begin
    rst = 1'b1; i_start = 0; i_num_pass = '0; i_clr = 0; i_valid = 0; i_ready = 0;
    i_psum = '0;
    test_reset();
    test_single_pass(4'd1);
    test_single_pass(4'd0);
    test_multi_pass();
`ifdef TILE_PSUM_SAT_EN
    test_saturation(524287, 8388607, 1'b1);
    test_saturation(-524288, -8388608, 1'b1);
`else
    test_saturation(524287, -6291476, 1'b0);
    test_saturation(-524288, 6291456, 1'b0);
`endif
    test_backpressure();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
